seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial sequence detector. It is the next generation of the fixed 2-bit-state bit-pattern FSM, with a runtime-loadable pattern of PAT_W bits, a selectable overlapping or non-overlapping match mode, input qualification, and a saturating match counter. It sits between a serial bit source and control logic that needs a one-cycle match pulse and running statistics.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; legal range ≥ 2.
- CNT_W, 8, width of the match counter; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  capture cfg_pattern/cfg_overlap and restart detection.
- cfg_pattern  in  PAT_W  pattern; MSB is the first bit received.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- bit_valid  in  1  qualifies bit_in.
- bit_in  in  1  serial data bit.
- count_clr  in  1  clears match_count and count_sat.
- armed  out  1  a pattern has been loaded (state ≠ IDLE).
- match  out  1  one-cycle pulse per detected pattern.
- match_count  out  CNT_W  saturating count of matches.
- count_sat  out  1  sticky flag; match_count has saturated.

## Operation
- State machine states are IDLE, FILL and RUN. Registers: pat, ovl, hist[PAT_W-1:0], fill (counts 0..PAT_W-1).
- Reset puts the block in IDLE with pat = 0, ovl = 0, hist = 0, fill = 0. All outputs reset to 0.
- IDLE: bit_valid is ignored. cfg_load moves the block to FILL.
- cfg_load, in any state:
  - captures pat and ovl;
  - clears hist and fill;
  - next state is FILL;
  - does not touch match_count.
  - If bit_valid is high in the same cycle, that bit is discarded (load wins).
- On each valid bit, the history shifts: hist <= {hist[PAT_W-2:0], bit_in}.
- FILL:
  - Each valid bit increments fill.
  - The valid bit that arrives when fill == PAT_W-1 completes the window. It is compared with pat and the state moves to RUN.
  - That bit can itself produce a match, handled as in RUN.
- RUN: each valid bit compares the next hist value against pat.
  - On a match with ovl = 1: stay in RUN.
  - On a match with ovl = 0: go to FILL with fill = 0; hist is cleared on this transition.
  - With no match: stay in RUN.
- bit_valid = 0 holds all state; gaps between valid bits never break a sequence.
- Counter:
  - On match, match_count increments.
  - When match_count = 2^CNT_W−1, it holds and count_sat is set.
  - count_clr sets match_count to 0 and clears count_sat.
  - count_clr in the same cycle as a new match: result is match_count = 1, count_sat = 0.
- reset overrides everything, including mid-fill and mid-match, and returns the block to IDLE, so a new cfg_load is required afterwards.

## Timing
- match is registered. It asserts in the cycle after the clock edge that samples the completing bit, for exactly one cycle.
- match_count reflects a match in the same cycle that match is high.
- armed rises one cycle after cfg_load is sampled.
- Back-to-back valid bits give at most one match per cycle. In overlapping mode, consecutive matches are possible only for periodic patterns (e.g. all-ones).
- The minimum time from cfg_load to the first match is PAT_W valid bits plus one cycle.

## Configuration
- SEQDET_COUNT_EN defined: the counter logic, match_count and count_sat are implemented as described above.
- SEQDET_COUNT_EN undefined:
  - match_count and count_sat are tied to 0 and count_clr is ignored.
  - match, armed and detection behaviour are unchanged.

## Structure
- Package seqdet_pkg holds the state_t enum (IDLE, FILL, RUN; 2-bit logic encoding) and the function localparam FILL_W = $clog2(PAT_W).
- Sub-module seq_match_counter (parameter CNT_W) holds the saturating counter and the sticky flag. It is instantiated only under SEQDET_COUNT_EN.
- The top level holds the FSM, history shifter and comparator.

## Test plan
- PAT_W=4, load 1011 with overlap=1, feed 1,0,1,1,0,1,1 -> match pulses after the 4th and 7th bits; match_count=2.
- Same stream with overlap=0 -> a single match after the 4th bit; match_count=1 (the trailing 011 only refills).
- Load 1111 with overlap=1, feed seven 1s -> matches after bits 4, 5, 6 and 7 on consecutive cycles.
- Feed 1011 with bit_valid low for 3 cycles between every bit -> one match; assert cfg_load together with bit_valid=1 mid-stream -> that bit is discarded and the block refills.
- CNT_W=2: 3 matches -> count=3 and count_sat=1; a 4th match leaves count at 3; count_clr together with a match -> count=1 and count_sat=0.
- reset asserted after 3 of 4 bits -> all outputs 0 and armed=0, and subsequent bits produce no match until cfg_load.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Width of the fill counter, which counts 0..pat_w-1.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a sticky saturation flag.
// A clear that coincides with a new match leaves the count at 1.
module seq_match_counter
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // Next count: clear has priority, otherwise increment until the maximum.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = CNT_W'(inc);
            sat_d   = 1'b0;
        end else begin
            if (inc && count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
            sat_d = sat_q | (count_d == CNT_MAX);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with a loadable pattern,
// overlapping / non-overlapping match modes and a one-cycle match pulse.
// Build option SEQDET_COUNT_EN adds the saturating match counter; without
// it match_count and count_sat read as zero and count_clr is ignored.
module seq_detect_param
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             count_clr,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int                FILL_W    = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_W - 1);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic [PAT_W-1:0]  hist_nxt;
    logic              win_full;

    // Next state, history shift and pattern compare; cfg_load beats bit_valid.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        match_d  = 1'b0;
        win_full = 1'b0;
        hist_nxt = {hist_q[PAT_W-2:0], bit_in};
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (bit_valid) begin
            case (state_q)
                FILL: begin
                    hist_d = hist_nxt;
                    if (fill_q == LAST_FILL) begin
                        win_full = 1'b1;
                        fill_d   = '0;
                        state_d  = RUN;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                RUN: begin
                    hist_d   = hist_nxt;
                    win_full = 1'b1;
                end
                default: ;
            endcase
            // A full window is compared; non-overlap mode restarts the fill.
            if (win_full && hist_nxt == pat_q) begin
                match_d = 1'b1;
                if (!ovl_q) begin
                    state_d = FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
        end
    end

    // Detector registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign armed = (state_q != IDLE);
    assign match = match_q;

`ifdef SEQDET_COUNT_EN
    // Counter sees the same pulse that sets match, so both update together.
    seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_d),
        .clr   (count_clr),
        .count (match_count),
        .sat   (count_sat)
    );
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
    assign count_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2) share
// stimulus; a queue-based reference model predicts match/armed/counters.
module tb_seq_detect_param;

    localparam int PAT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             cfg_overlap = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             count_clr = 1'b0;

    logic       armed_a, match_a, sat_a;
    logic [7:0] cnt_a;
    logic       armed_b, match_b, sat_b;
    logic [1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit             m_armed = 0;
    bit [PAT_W-1:0] m_pat = '0;
    bit             m_ovl = 0;
    bit             m_match = 0;
    bit             q[$];
    int             m_cnt_a = 0, m_cnt_b = 0;
    bit             m_sat_a = 0, m_sat_b = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .bit_valid(bit_valid), .bit_in(bit_in),
        .count_clr(count_clr), .armed(armed_a), .match(match_a),
        .match_count(cnt_a), .count_sat(sat_a)
    );

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .bit_valid(bit_valid), .bit_in(bit_in),
        .count_clr(count_clr), .armed(armed_b), .match(match_b),
        .match_count(cnt_b), .count_sat(sat_b)
    );

    function automatic int cexp(input int v);
`ifdef SEQDET_COUNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Saturating counter rule: clear wins (a coincident match leaves 1).
    task automatic cnt_rule(inout int c, inout bit s, input int mx, input bit inc, input bit clr);
        if (clr) begin
            c = inc ? 1 : 0;
            s = 0;
        end else begin
            if (inc && c < mx) c = c + 1;
            if (c == mx) s = 1;
        end
    endtask

    // Model of one clock edge with the inputs that edge samples.
    task automatic model_edge(input bit rst, ld, input bit [PAT_W-1:0] p,
                              input bit ov, bv, bi, clr);
        int w;
        m_match = 0;
        if (rst) begin
            m_armed = 0; m_pat = '0; m_ovl = 0; q.delete();
            m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 0; m_sat_b = 0;
            return;
        end
        if (ld) begin
            m_armed = 1; m_pat = p; m_ovl = ov; q.delete();
        end else if (m_armed && bv) begin
            q.push_back(bi);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (q.size() == PAT_W) begin
                w = 0;
                foreach (q[i]) w = w * 2 + int'(q[i]);
                if (w == int'(m_pat)) begin
                    m_match = 1;
                    if (!m_ovl) q.delete();
                end
            end
        end
        cnt_rule(m_cnt_a, m_sat_a, 255, m_match, clr);
        cnt_rule(m_cnt_b, m_sat_b, 3, m_match, clr);
    endtask

    task automatic step(input bit rst, ld, input bit [PAT_W-1:0] p,
                        input bit ov, bv, bi, clr);
        reset = rst; cfg_load = ld; cfg_pattern = p; cfg_overlap = ov;
        bit_valid = bv; bit_in = bi; count_clr = clr;
        @(posedge clk);
        #1;
        model_edge(rst, ld, p, ov, bv, bi, clr);
        chk("match_a", 32'(match_a), 32'(m_match));
        chk("armed_a", 32'(armed_a), 32'(m_armed));
        chk("cnt_a",   32'(cnt_a),   cexp(m_cnt_a));
        chk("sat_a",   32'(sat_a),   cexp(int'(m_sat_a)));
        chk("match_b", 32'(match_b), 32'(m_match));
        chk("cnt_b",   32'(cnt_b),   cexp(m_cnt_b));
        chk("sat_b",   32'(sat_b),   cexp(int'(m_sat_b)));
    endtask

    task automatic feed(input bit b);      step(0, 0, '0, 0, 1, b, 0); endtask
    task automatic idle();                 step(0, 0, '0, 0, 0, 0, 0); endtask
    task automatic load(input bit [PAT_W-1:0] p, input bit ov); step(0, 1, p, ov, 0, 0, 0); endtask
    task automatic clr();                  step(0, 0, '0, 0, 0, 0, 1); endtask

    initial begin
        bit [6:0] s1;
        // Reset state.
        step(1, 0, '0, 0, 0, 0, 0);
        chk("rst_armed", 32'(armed_a), 0);
        chk("rst_match", 32'(match_a), 0);
        idle();
        // Bits before any load are ignored.
        feed(1); feed(0); feed(1); feed(1);
        chk("idle_cnt", 32'(cnt_a), 0);

        // 1011 overlapping: matches after bits 4 and 7.
        s1 = 7'b1011011;
        load(4'b1011, 1);
        chk("load_armed", 32'(armed_a), 1);
        for (int i = 6; i >= 0; i--) feed(s1[i]);
        chk("t1_cnt", 32'(cnt_a), cexp(2));

        // Same stream non-overlapping: single match.
        clr();
        load(4'b1011, 0);
        for (int i = 6; i >= 0; i--) feed(s1[i]);
        chk("t2_cnt", 32'(cnt_a), cexp(1));

        // 1111 overlapping, seven ones: four matches back to back; CNT_W=2 saturates.
        clr();
        load(4'b1111, 1);
        for (int i = 0; i < 7; i++) feed(1);
        chk("t3_cnt", 32'(cnt_a), cexp(4));
        chk("t3_cntb", 32'(cnt_b), cexp(3));
        chk("t3_satb", 32'(sat_b), cexp(1));
        // Clear together with a match.
        step(0, 0, '0, 0, 1, 1, 1);
        chk("t3_clr_cntb", 32'(cnt_b), cexp(1));
        chk("t3_clr_satb", 32'(sat_b), 0);

        // Gaps between bits never break the sequence.
        clr();
        load(4'b1011, 0);
        s1 = 7'b0001011;
        for (int i = 3; i >= 0; i--) begin
            feed(s1[i]);
            idle(); idle(); idle();
        end
        chk("t4_cnt", 32'(cnt_a), cexp(1));
        // Load with a valid bit mid-stream: bit discarded, window refills.
        feed(1); feed(0);
        step(0, 1, 4'b1011, 0, 1, 1, 0);
        feed(0); feed(1); feed(1);
        chk("t4_refill", 32'(cnt_a), cexp(1));
        feed(1); feed(0); feed(1); feed(1);
        chk("t4_after", 32'(cnt_a), cexp(2));

        // Reset mid-fill, then bits without a load.
        load(4'b1011, 1);
        feed(1); feed(0); feed(1);
        step(1, 0, '0, 0, 1, 1, 0);
        chk("t5_armed", 32'(armed_a), 0);
        chk("t5_cnt", 32'(cnt_a), 0);
        for (int i = 0; i < 8; i++) feed(i[0]);
        feed(1); feed(0); feed(1); feed(1);

        // Randomized traffic.
        load(4'($urandom), 1'($urandom));
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 24) == 0,
                 4'($urandom_range(0, 3) == 0 ? 15 : $urandom),
                 1'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0);
            if (!m_armed) load(4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
